// File: rtl/dpc_bp_collector_pkg.sv
// Shared definitions for the DPC auto bad-pixel collector: geometry, state
// encoding, coordinate packing and raster-order key.
package dpc_bp_collector_pkg;

  localparam int CNT_WIDTH     = 10;
  localparam int AUTO_BP_NUM   = 256;
  localparam int AUTO_BP_BIT   = 8;
  localparam int MANUAL_BP_BIT = 7;
  localparam int FRAME_WIDTH   = 640;
  localparam int FRAME_HEIGHT  = 512;

  localparam int KEY_W  = 2 * CNT_WIDTH;
  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_READY,
    ST_EXPORT
  } bp_state_e;

  // Word layout shared with the manual bad-pixel checker's wdata decode.
  function automatic logic [31:0] pack_coord(input logic [CNT_WIDTH-1:0] x,
                                             input logic [CNT_WIDTH-1:0] y);
    logic [31:0] w;
    w = '0;
    w[X_LSB +: CNT_WIDTH] = x;
    w[Y_LSB +: CNT_WIDTH] = y;
    return w;
  endfunction

  function automatic logic [KEY_W-1:0] raster_key(input logic [CNT_WIDTH-1:0] x,
                                                  input logic [CNT_WIDTH-1:0] y);
    return KEY_W'(y) * KEY_W'(FRAME_WIDTH) + KEY_W'(x);
  endfunction

endpackage

// File: rtl/dpc_bp_collector_table.sv
// Coordinate table RAM: one write port, two independent synchronous read ports
// (host readback and export replay).
module dpc_bp_table #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 20
) (
  input  logic          aclk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          ren_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren_a) rdata_a <= mem[raddr_a];
    if (ren_b) rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/dpc_bp_collector.sv
// Collects one frame of auto-detected bad pixels into an ascending, deduplicated
// table, serves host reads, and replays the table into the manual LUT.
module dpc_bp_collector
  import dpc_bp_collector_pkg::*;
(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     capture_en,
  input  logic                     frame_start,
  input  logic                     frame_done,
  input  logic                     bp_in_valid,
  input  logic [CNT_WIDTH-1:0]     bp_in_x,
  input  logic [CNT_WIDTH-1:0]     bp_in_y,
  input  logic                     rd_req,
  input  logic [AUTO_BP_BIT-1:0]   rd_addr,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [AUTO_BP_BIT:0]     bp_count,
  output logic                     overflow,
  output logic                     list_ready,
  input  logic                     export_start,
  output logic                     manual_wen,
  output logic [MANUAL_BP_BIT-1:0] manual_waddr,
  output logic [31:0]              manual_wdata,
  output logic [MANUAL_BP_BIT-1:0] manual_bp_num,
  output logic                     export_busy,
  output logic                     export_done
);

  localparam logic [AUTO_BP_BIT:0] TABLE_FULL = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);
  localparam logic [AUTO_BP_BIT:0] MANUAL_MAX = (AUTO_BP_BIT+1)'((1 << MANUAL_BP_BIT) - 1);

  bp_state_e state, state_nxt;

  logic [KEY_W-1:0]         in_key, last_key;
  logic                     last_valid;
  logic                     in_range, in_newer;
  logic                     cap_clear, tbl_wen, ovf_set;
  logic                     exp_enter, exp_rd, exp_finish;
  logic [MANUAL_BP_BIT-1:0] exp_idx, exp_n;
  logic                     rd_hit;
  logic [KEY_W-1:0]         q_host, q_exp;

  assign in_key   = raster_key(bp_in_x, bp_in_y);
  assign in_range = (bp_in_x < CNT_WIDTH'(FRAME_WIDTH)) && (bp_in_y < CNT_WIDTH'(FRAME_HEIGHT));
  assign in_newer = !last_valid || (in_key > last_key);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A restart frame_start in CAPTURE wins over frame_done and drops any
  // coincident pixel, since the count is being cleared on that same edge.
  always_comb begin
    state_nxt  = state;
    cap_clear  = 1'b0;
    tbl_wen    = 1'b0;
    ovf_set    = 1'b0;
    exp_enter  = 1'b0;
    exp_rd     = 1'b0;
    exp_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start && capture_en) begin
          state_nxt = ST_CAPTURE;
          cap_clear = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (frame_start && capture_en) begin
          cap_clear = 1'b1;
        end else begin
          if (bp_in_valid && in_range && in_newer) begin
            if (bp_count < TABLE_FULL) tbl_wen = 1'b1;
            else                       ovf_set = 1'b1;
          end
          if (frame_done) state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (frame_start && capture_en) begin
          state_nxt = ST_CAPTURE;
          cap_clear = 1'b1;
        end else if (export_start) begin
          state_nxt = ST_EXPORT;
          exp_enter = 1'b1;
        end
      end
      ST_EXPORT: begin
        if (exp_idx == exp_n) begin
          state_nxt  = ST_READY;
          exp_finish = 1'b1;
        end else begin
          exp_rd = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bp_count   <= '0;
      overflow   <= 1'b0;
      last_valid <= 1'b0;
      last_key   <= '0;
    end else if (cap_clear) begin
      bp_count   <= '0;
      overflow   <= 1'b0;
      last_valid <= 1'b0;
    end else begin
      if (tbl_wen) begin
        bp_count   <= bp_count + 1'b1;
        last_key   <= in_key;
        last_valid <= 1'b1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Export reads entry i in EXPORT cycle i; the LUT write follows one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      exp_idx       <= '0;
      exp_n         <= '0;
      manual_wen    <= 1'b0;
      manual_waddr  <= '0;
      manual_bp_num <= '0;
      export_done   <= 1'b0;
    end else begin
      manual_wen  <= exp_rd;
      export_done <= exp_finish;
      if (exp_enter) begin
        exp_idx <= '0;
        exp_n   <= (bp_count > MANUAL_MAX) ? MANUAL_MAX[MANUAL_BP_BIT-1:0]
                                           : bp_count[MANUAL_BP_BIT-1:0];
      end else if (exp_rd) begin
        exp_idx <= exp_idx + 1'b1;
      end
      if (exp_rd)     manual_waddr  <= exp_idx;
      if (exp_finish) manual_bp_num <= exp_n;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)
        rd_hit <= ((state == ST_READY) || (state == ST_EXPORT)) &&
                  ({1'b0, rd_addr} < bp_count);
    end
  end

  assign rd_data      = rd_hit ? pack_coord(q_host[CNT_WIDTH-1:0], q_host[KEY_W-1:CNT_WIDTH]) : 32'd0;
  assign manual_wdata = manual_wen ? pack_coord(q_exp[CNT_WIDTH-1:0], q_exp[KEY_W-1:CNT_WIDTH]) : 32'd0;
  assign list_ready   = (state == ST_READY);
  assign export_busy  = (state == ST_EXPORT);

  dpc_bp_table #(
    .DEPTH (AUTO_BP_NUM),
    .AW    (AUTO_BP_BIT),
    .DW    (KEY_W)
  ) u_table (
    .aclk    (aclk),
    .wen     (tbl_wen),
    .waddr   (bp_count[AUTO_BP_BIT-1:0]),
    .wdata   ({bp_in_y, bp_in_x}),
    .ren_a   (rd_req),
    .raddr_a (rd_addr),
    .rdata_a (q_host),
    .ren_b   (exp_rd),
    .raddr_b (AUTO_BP_BIT'(exp_idx)),
    .rdata_b (q_exp)
  );

endmodule

// File: tb/tb_dpc_bp_collector.sv
// Self-checking bench for dpc_bp_collector: vector tables, directed corner
// sequences and randomized frames against a queue-based reference model.
module tb_dpc_bp_collector;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        capture_en, frame_start, frame_done, bp_in_valid;
  logic [9:0]  bp_in_x, bp_in_y;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [8:0]  bp_count;
  logic        overflow, list_ready, export_start;
  logic        manual_wen;
  logic [6:0]  manual_waddr;
  logic [31:0] manual_wdata;
  logic [6:0]  manual_bp_num;
  logic        export_busy, export_done;

  int vec_count  = 0;
  int miss_count = 0;

  int model_q[$];
  int model_last;
  bit model_ovf;

  typedef struct {
    int x;
    int y;
    int exp_count;
  } vec_t;

  vec_t t1[3];
  vec_t t2[5];
  logic [31:0] t1_data[4];

  always #5 aclk = ~aclk;

  dpc_bp_collector dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .capture_en    (capture_en),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .bp_in_valid   (bp_in_valid),
    .bp_in_x       (bp_in_x),
    .bp_in_y       (bp_in_y),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .bp_count      (bp_count),
    .overflow      (overflow),
    .list_ready    (list_ready),
    .export_start  (export_start),
    .manual_wen    (manual_wen),
    .manual_waddr  (manual_waddr),
    .manual_wdata  (manual_wdata),
    .manual_bp_num (manual_bp_num),
    .export_busy   (export_busy),
    .export_done   (export_done)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int packXY(input int x, input int y);
    return (y * 65536) + x;
  endfunction

  // Reference store rule: in-frame, strictly later in raster order, room left.
  task automatic modelPoint(input int x, input int y);
    int key;
    if (x >= 640 || y >= 512) return;
    key = y * 640 + x;
    if (key <= model_last) return;
    if (model_q.size() >= 256) begin
      model_ovf = 1'b1;
      return;
    end
    model_q.push_back(packXY(x, y));
    model_last = key;
  endtask

  task automatic startCapture();
    capture_en  = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_q.delete();
    model_last = -1;
    model_ovf  = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y);
    bp_in_valid = 1'b1;
    bp_in_x     = 10'(x);
    bp_in_y     = 10'(y);
    tick();
    bp_in_valid = 1'b0;
    modelPoint(x, y);
  endtask

  task automatic endCapture();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic readCheck(input string name, input int addr, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_addr = 8'(addr);
    tick();
    rd_req  = 1'b0;
    checkOutput({name, "_rd_valid"}, 32'(rd_valid), 32'd1);
    checkOutput(name, rd_data, exp);
  endtask

  task automatic checkList(input string name);
    checkOutput({name, "_count"}, 32'(bp_count), 32'(model_q.size()));
    checkOutput({name, "_overflow"}, 32'(overflow), 32'(model_ovf));
    checkOutput({name, "_ready"}, 32'(list_ready), 32'd1);
    for (int i = 0; i < model_q.size(); i++)
      readCheck($sformatf("%s_entry%0d", name, i), i, 32'(model_q[i]));
    if (model_q.size() < 256)
      readCheck({name, "_beyond"}, model_q.size(), 32'd0);
  endtask

  // Runs one export and checks every cycle; fs_cycle>0 pulses frame_start there.
  task automatic runExport(input string name, input int fs_cycle);
    int n;
    n = (model_q.size() > 127) ? 127 : model_q.size();
    export_start = 1'b1;
    tick();
    export_start = 1'b0;
    checkOutput({name, "_busy"}, 32'(export_busy), 32'd1);
    checkOutput({name, "_wen0"}, 32'(manual_wen), 32'd0);
    for (int c = 1; c <= n + 3; c++) begin
      capture_en  = 1'b1;
      frame_start = (c == fs_cycle);
      tick();
      frame_start = 1'b0;
      checkOutput($sformatf("%s_wen_c%0d", name, c), 32'(manual_wen), 32'(c <= n));
      if (manual_wen && c <= n) begin
        checkOutput($sformatf("%s_waddr_c%0d", name, c), 32'(manual_waddr), 32'(c - 1));
        checkOutput($sformatf("%s_wdata_c%0d", name, c), manual_wdata, 32'(model_q[c-1]));
      end
      checkOutput($sformatf("%s_done_c%0d", name, c), 32'(export_done), 32'(c == n + 1));
      if (c == n + 1) begin
        checkOutput({name, "_bp_num"}, 32'(manual_bp_num), 32'(n));
        checkOutput({name, "_busy_end"}, 32'(export_busy), 32'd0);
      end
    end
    checkOutput({name, "_ready_after"}, 32'(list_ready), 32'd1);
    checkOutput({name, "_count_after"}, 32'(bp_count), 32'(model_q.size()));
  endtask

  initial begin
    int key, x, y;

    t1[0] = '{3, 0, 1};
    t1[1] = '{5, 2, 2};
    t1[2] = '{639, 511, 3};
    t1_data[0] = 32'h0000_0003;
    t1_data[1] = 32'h0002_0005;
    t1_data[2] = 32'h01FF_027F;
    t1_data[3] = 32'h0000_0000;
    t2[0] = '{10, 4, 1};
    t2[1] = '{10, 4, 1};
    t2[2] = '{2, 4, 1};
    t2[3] = '{11, 4, 2};
    t2[4] = '{700, 1, 2};

    aresetn = 1'b0;
    capture_en = 0; frame_start = 0; frame_done = 0; bp_in_valid = 0;
    bp_in_x = 0; bp_in_y = 0; rd_req = 0; rd_addr = 0; export_start = 0;
    model_last = -1; model_ovf = 0;
    tick(); tick();
    checkOutput("reset_count", 32'(bp_count), 0);
    checkOutput("reset_ready", 32'(list_ready), 0);
    checkOutput("reset_busy", 32'(export_busy), 0);
    checkOutput("reset_wen", 32'(manual_wen), 0);
    checkOutput("reset_rd_data", rd_data, 0);
    aresetn = 1'b1;
    tick();

    // frame_start without capture_en must leave the block idle
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bp_in_valid = 1'b1; bp_in_x = 10'd1; bp_in_y = 10'd1; frame_done = 1'b1;
    tick();
    bp_in_valid = 1'b0; frame_done = 1'b0;
    tick();
    checkOutput("noarm_count", 32'(bp_count), 0);
    checkOutput("noarm_ready", 32'(list_ready), 0);

    // Capture and read back
    startCapture();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(t1[i].x, t1[i].y);
      checkOutput($sformatf("t1_count%0d", i), 32'(bp_count), 32'(t1[i].exp_count));
    end
    readCheck("t1_rd_in_capture", 0, 32'd0);
    endCapture();
    checkOutput("t1_ready", 32'(list_ready), 1);
    for (int i = 0; i < 4; i++)
      readCheck($sformatf("t1_rd%0d", i), i, t1_data[i]);

    // Dedup and order filtering
    startCapture();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t2[i].x, t2[i].y);
      checkOutput($sformatf("t2_count%0d", i), 32'(bp_count), 32'(t2[i].exp_count));
    end
    endCapture();
    checkOutput("t2_overflow", 32'(overflow), 0);
    readCheck("t2_rd0", 0, 32'h0004_000A);
    readCheck("t2_rd1", 1, 32'h0004_000B);
    readCheck("t2_rd2", 2, 32'd0);

    // Overflow, then clearing on the next capture start
    startCapture();
    for (int i = 0; i < 300; i++) applyStimulus((i * 3) % 640, (i * 3) / 640);
    endCapture();
    checkOutput("t3_count", 32'(bp_count), 256);
    checkOutput("t3_overflow", 32'(overflow), 1);
    readCheck("t3_last", 255, 32'h0001_007D);
    startCapture();
    checkOutput("t3_clr_count", 32'(bp_count), 0);
    checkOutput("t3_clr_overflow", 32'(overflow), 0);
    endCapture();

    // Export of 200 entries (capped at 127), frame_start ignored mid-export
    startCapture();
    for (int i = 0; i < 200; i++) applyStimulus((i * 2) % 640, (i * 2) / 640);
    endCapture();
    checkOutput("t4_count", 32'(bp_count), 200);
    runExport("t4", 5);

    // Empty export
    startCapture();
    endCapture();
    runExport("t4_empty", 0);

    // frame_done coincident with a valid pixel
    startCapture();
    bp_in_valid = 1'b1; bp_in_x = 10'd4; bp_in_y = 10'd4; frame_done = 1'b1;
    tick();
    bp_in_valid = 1'b0; frame_done = 1'b0;
    modelPoint(4, 4);
    checkOutput("t5a_ready", 32'(list_ready), 1);
    checkOutput("t5a_count", 32'(bp_count), 1);
    readCheck("t5a_rd0", 0, 32'h0004_0004);

    // Restart mid-capture
    startCapture();
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    checkOutput("t5b_pre", 32'(bp_count), 3);
    startCapture();
    checkOutput("t5b_count", 32'(bp_count), 0);
    checkOutput("t5b_not_ready", 32'(list_ready), 0);
    applyStimulus(0, 0);
    endCapture();
    checkList("t5b");

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      startCapture();
      key = 0;
      for (int j = 0; j < 60 + f * 20; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
        end else if ($urandom_range(0, 7) == 0) begin
          applyStimulus($urandom_range(640, 1023), $urandom_range(0, 1023));
        end else begin
          key = key + $urandom_range(0, 2400) - 300;
          if (key < 0) key = 0;
          if (key > 327679) key = 327679;
          x = key % 640;
          y = key / 640;
          applyStimulus(x, y);
        end
      end
      endCapture();
      checkList($sformatf("rnd%0d", f));
      runExport($sformatf("rnd%0d_exp", f), 0);
    end

    // Asynchronous reset in the middle of an export
    startCapture();
    for (int i = 0; i < 50; i++) applyStimulus(i, 7);
    endCapture();
    export_start = 1'b1;
    tick();
    export_start = 1'b0;
    tick(); tick(); tick();
    checkOutput("t6_wen_before", 32'(manual_wen), 1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_wen", 32'(manual_wen), 0);
    checkOutput("t6_busy", 32'(export_busy), 0);
    checkOutput("t6_ready", 32'(list_ready), 0);
    checkOutput("t6_count", 32'(bp_count), 0);
    checkOutput("t6_overflow", 32'(overflow), 0);
    checkOutput("t6_bp_num", 32'(manual_bp_num), 0);
    checkOutput("t6_waddr", 32'(manual_waddr), 0);
    checkOutput("t6_wdata", manual_wdata, 0);
    checkOutput("t6_done", 32'(export_done), 0);
    checkOutput("t6_rd_data", rd_data, 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    readCheck("t6_rd_after", 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/dpc_bp_collector.md
Name: dpc_bp_collector

Overview:
- Consumer end of the DPC detector's auto bad-pixel output (valid/x/y per pixel, raster order).
- Captures one frame's detected coordinates into an internal table, deduplicated and kept strictly ascending.
- The host reads the table back by address.
- On command, the block replays the table as writes to the manual bad-pixel LUT interface (wen/waddr/wdata/bp_num), so auto-detected points become manual points.

Parameters:
- CNT_WIDTH, 10, coordinate width
- AUTO_BP_NUM, 256, table depth
- AUTO_BP_BIT, 8, table address width (log2 AUTO_BP_NUM)
- MANUAL_BP_BIT, 7, manual LUT address width
- FRAME_WIDTH, 640, pixels per line
- FRAME_HEIGHT, 512, lines per frame

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- capture_en  in  1  arm capture on the next frame_start
- frame_start  in  1  SOF pulse, one cycle
- frame_done  in  1  frame-detection-done pulse, one cycle
- bp_in_valid  in  1  detected bad pixel this cycle
- bp_in_x  in  CNT_WIDTH  column
- bp_in_y  in  CNT_WIDTH  row
- rd_req  in  1  host read strobe
- rd_addr  in  AUTO_BP_BIT  host read index
- rd_valid  out  1  host read data valid
- rd_data  out  32  {6'b0, y, 6'b0, x}
- bp_count  out  AUTO_BP_BIT+1  entries stored
- overflow  out  1  sticky: an entry was dropped because the table was full
- list_ready  out  1  table closed and readable (state READY)
- export_start  in  1  replay table into the manual LUT
- manual_wen  out  1  LUT write strobe
- manual_waddr  out  MANUAL_BP_BIT  LUT address
- manual_wdata  out  32  same packing as rd_data
- manual_bp_num  out  MANUAL_BP_BIT  manual entry count, updated on export_done
- export_busy  out  1  state EXPORT
- export_done  out  1  one-cycle pulse

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-low on aresetn.
- Reset values: state IDLE; all outputs 0; table contents don't-care.

State machine (IDLE, CAPTURE, READY, EXPORT):
- IDLE -> CAPTURE on frame_start & capture_en. On entry: bp_count=0, overflow=0, last-coordinate register invalid.
- CAPTURE -> READY on frame_done. A bp_in_valid in the same cycle as frame_done is stored first.
- CAPTURE -> CAPTURE restart on frame_start (frame_done was missed). Count and overflow clear.
- READY -> CAPTURE on frame_start & capture_en.
- READY -> EXPORT on export_start.
- EXPORT -> READY after the last write. frame_start is ignored while in EXPORT.
- frame_start with capture_en=0 is ignored in every state.

Store rule (CAPTURE only), applied when bp_in_valid=1:
- The entry is written only if all of the following hold:
  - x < FRAME_WIDTH and y < FRAME_HEIGHT;
  - raster key y*FRAME_WIDTH+x is strictly greater than the last stored key (this drops duplicates and out-of-order entries);
  - bp_count < AUTO_BP_NUM.
- If only the capacity test fails, the entry is dropped and overflow is set.
- The write lands in the same cycle; bp_count increments one cycle later.

Host read:
- rd_valid is asserted exactly 1 cycle after rd_req, in any state.
- rd_data holds the table entry only when the state is READY or EXPORT and rd_addr < bp_count; otherwise 0.
- The table has a dedicated read port for the host, independent of the export read port.

Export:
- n = min(bp_count, 2^MANUAL_BP_BIT - 1).
- Entry i is read at cycle i after entry to EXPORT.
- manual_wen is asserted at cycle i+1 with manual_waddr=i and manual_wdata=entry i.
- One write per cycle, n writes in total.
- export_done pulses at cycle n+1; manual_bp_num=n from that same cycle.
- For n=0: no wen; export_done at cycle 1.
- export_start outside READY is ignored.

Decomposition:
- Shared dpc package holds:
  - the coordinate packing function/offsets (x at [9:0], y at [25:16]), which must match the manual checker's wdata decode;
  - the state encoding;
  - the raster-key compute.
- Sub-module: dpc_bp_table, a depth AUTO_BP_NUM × 2·CNT_WIDTH RAM with 1 write port and 2 synchronous read ports.

Test Plan:
1. Capture and read back.
   - Stimulus: capture_en=1, frame_start; valid at (3,0), (5,2), (639,511); frame_done; rd_req addr 0,1,2,3.
   - Required: bp_count=3, list_ready=1; rd_data = 0x00000003, 0x00020005, 0x01FF027F, then 0.
2. Dedup and order filtering.
   - Stimulus: inputs (10,4), (10,4), (2,4), (11,4), (700,1).
   - Required: only (10,4) and (11,4) are stored; bp_count=2; overflow=0.
3. Overflow.
   - Stimulus: 300 ascending points in one frame.
   - Required: bp_count=256, overflow=1. The next capture start clears both.
4. Export.
   - Stimulus: bp_count=200, export_start.
   - Required: 127 consecutive manual_wen with waddr 0..126 and the matching data; export_done at cycle 128; manual_bp_num=127.
   - Repeat with bp_count=0: export_done at cycle 1, no wen, manual_bp_num=0.
5. Boundary events.
   - Case a: frame_done coincident with valid (4,4) -> entry stored, READY.
   - Case b: frame_start mid-CAPTURE -> bp_count=0 next cycle.
   - Case c: frame_start during EXPORT -> ignored.
6. Reset.
   - Stimulus: aresetn low mid-EXPORT.
   - Required: manual_wen drops immediately; all outputs 0, state IDLE; rd_data after reset is 0.
